// File: rtl/pr_allocator_pkg.sv
// Shared constants, types and helpers for the physical-register allocator.
// NUM_ARCH_REGS fixes how many low PRs hold the initial architectural mappings.
// pr_idx_t is the PR index type for the default 64-register build.
package pr_allocator_pkg;

  localparam int NUM_ARCH_REGS    = 32;
  localparam int DEF_NUM_PHY_REGS = 64;
  localparam int DEF_PRW          = $clog2(DEF_NUM_PHY_REGS);

  typedef logic [DEF_PRW-1:0] pr_idx_t;

  // Circular index advance. Valid whenever off < depth, so a single
  // conditional subtract replaces a modulo for non-power-of-two depths.
  function automatic int wrap_add(input int base, input int off, input int depth);
    int s;
    s = base + off;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

endpackage

// File: rtl/pr_allocator_free_fifo.sv
// Circular free-PR store: up to NUM_POP pops and one push per cycle.
// Latency: reads are combinational from head; push/pop take effect at the clock edge.
// Backpressure: none; the caller never pops more than count and never overfills.
//
// Ports: clk, rst_n (async active-low); pop_cnt (entries consumed this cycle);
//   push_vld/push_dat (one PR returned this cycle); rd_dat[k] = entry head+k;
//   count (registered occupancy). Reset loads NUM_ARCH_REGS..NUM_ARCH_REGS+DEPTH-1.
module pr_free_fifo
  import pr_allocator_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int W       = 6,
  parameter int NUM_POP = 2,
  parameter int CW      = 7,
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int GW     = $clog2(NUM_POP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [GW-1:0] pop_cnt,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  output logic [W-1:0]  rd_dat [NUM_POP],
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic [CW:0]   count_nxt;

  always_comb begin
    for (int k = 0; k < NUM_POP; k++) begin
      rd_dat[k] = mem[IW'(wrap_add(int'(head), k, DEPTH))];
    end
  end

  // One spare bit so an overfill is visible rather than wrapping.
  assign count_nxt = (CW+1)'(count) - (CW+1)'(pop_cnt) + (CW+1)'(push_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= W'(NUM_ARCH_REGS + i);
      end
      head  <= '0;
      tail  <= '0;
      count <= CW'(DEPTH);
    end else begin
      head <= IW'(wrap_add(int'(head), int'(pop_cnt), DEPTH));
      if (push_vld) begin
        mem[tail] <= push_dat;
        tail      <= IW'(wrap_add(int'(tail), 1, DEPTH));
      end
      count <= count_nxt[CW-1:0];
    end
  end

  // Only a PR returned twice can push the store past its depth.
  a_no_overfill: assert property (@(posedge clk) disable iff (!rst_n)
    count_nxt <= (CW+1)'(DEPTH))
    else $fatal(1, "pr_free_fifo overfill");

endmodule

// File: rtl/pr_allocator.sv
// Physical-register free-list manager: grants free PRs to SIC rename ports, recycles idle reclaimed PRs.
// Latency: grant is combinational; reclaim -> pending at edge N, drain at N+1, grantable in cycle N+2.
// Backpressure: a request is simply not granted when free entries run out; reclaims are never stalled.
//
// Ports: clk, rst_n (async active-low); alloc_req/alloc_gnt/alloc_pr per SIC, mirrored on
//   rf_alloc_wen/rf_alloc_pr; reclaim_valid/reclaim_pr per SIC; pr_not_idle blocks recycling;
//   free_count/free_empty (registered); err_double_free (one-cycle pulse).
// Build option PRA_DOUBLE_FREE_CHECK_EN: tracks PRs sitting in the free store and drops reclaims
//   of PRs already free or pending, pulsing err_double_free. Without it err_double_free is 0.
module pr_allocator
  import pr_allocator_pkg::*;
#(
  parameter int NUM_PHY_REGS = 64,
  parameter int NUM_SICS     = 2,
  localparam int PRW         = $clog2(NUM_PHY_REGS),
  localparam int D           = NUM_PHY_REGS - NUM_ARCH_REGS,
  localparam int GW          = $clog2(NUM_SICS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SICS-1:0]     alloc_req,
  output logic [NUM_SICS-1:0]     alloc_gnt,
  output logic [PRW-1:0]          alloc_pr [NUM_SICS],
  output logic [NUM_SICS-1:0]     rf_alloc_wen,
  output logic [PRW-1:0]          rf_alloc_pr [NUM_SICS],
  input  logic [NUM_SICS-1:0]     reclaim_valid,
  input  logic [PRW-1:0]          reclaim_pr [NUM_SICS],
  input  logic [NUM_PHY_REGS-1:0] pr_not_idle,
  output logic [PRW:0]            free_count,
  output logic                    free_empty,
  output logic                    err_double_free
);

  logic [PRW-1:0]          fifo_rd [NUM_SICS];
  logic [GW-1:0]           pop_cnt;
  logic [NUM_PHY_REGS-1:0] pend;
  logic [NUM_PHY_REGS-1:0] set_mask;
  logic [NUM_PHY_REGS-1:0] drain_mask;
  logic                    drain_vld;
  logic [PRW-1:0]          drain_pr;
  logic [NUM_SICS-1:0]     rec_hi;

  pr_free_fifo #(
    .DEPTH   (D),
    .W       (PRW),
    .NUM_POP (NUM_SICS),
    .CW      (PRW + 1)
  ) u_free_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .pop_cnt  (pop_cnt),
    .push_vld (drain_vld),
    .push_dat (drain_pr),
    .rd_dat   (fifo_rd),
    .count    (free_count)
  );

  assign free_empty = (free_count == '0);

  // Grant chain: lower SIC index first. Gated by rst_n so grants vanish the
  // moment reset asserts, even though the store itself resets to full.
  always_comb begin
    pop_cnt   = '0;
    alloc_gnt = '0;
    for (int s = 0; s < NUM_SICS; s++) begin
      alloc_pr[s] = '0;
      if (rst_n && alloc_req[s] && ((PRW+1)'(pop_cnt) < free_count)) begin
        alloc_gnt[s] = 1'b1;
        for (int k = 0; k < NUM_SICS; k++) begin
          if (GW'(k) == pop_cnt) alloc_pr[s] = fifo_rd[k];
        end
        pop_cnt = pop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rf_alloc_wen = alloc_gnt;
    for (int s = 0; s < NUM_SICS; s++) rf_alloc_pr[s] = alloc_pr[s];
  end

  // Lowest-index idle pending PR is returned. Low architectural bits of pend
  // are never set, so scanning the whole vector picks the same PR.
  always_comb begin
    drain_vld  = 1'b0;
    drain_pr   = '0;
    drain_mask = '0;
    for (int p = NUM_PHY_REGS - 1; p >= 0; p--) begin
      if (pend[p] && !pr_not_idle[p]) begin
        drain_vld = 1'b1;
        drain_pr  = PRW'(p);
      end
    end
    if (drain_vld) drain_mask[drain_pr] = 1'b1;
  end

`ifdef PRA_DOUBLE_FREE_CHECK_EN
  logic [NUM_PHY_REGS-1:0] infl;
  logic [NUM_PHY_REGS-1:0] grant_mask;
  logic                    dbl_free;
`endif

  always_comb begin
    set_mask = '0;
    rec_hi   = '0;
`ifdef PRA_DOUBLE_FREE_CHECK_EN
    dbl_free = 1'b0;
`endif
    for (int s = 0; s < NUM_SICS; s++) begin
      rec_hi[s] = (reclaim_pr[s] >= PRW'(NUM_ARCH_REGS));
      if (reclaim_valid[s] && rec_hi[s]) begin
`ifdef PRA_DOUBLE_FREE_CHECK_EN
        if (infl[reclaim_pr[s]] || pend[reclaim_pr[s]]) dbl_free = 1'b1;
        else set_mask[reclaim_pr[s]] = 1'b1;
`else
        set_mask[reclaim_pr[s]] = 1'b1;
`endif
      end
    end
  end

  // A reclaim landing on the PR being drained this cycle keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~drain_mask) | set_mask;
  end

`ifdef PRA_DOUBLE_FREE_CHECK_EN
  always_comb begin
    grant_mask = '0;
    for (int s = 0; s < NUM_SICS; s++) begin
      if (alloc_gnt[s]) grant_mask[alloc_pr[s]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl            <= {{D{1'b1}}, {NUM_ARCH_REGS{1'b0}}};
      err_double_free <= 1'b0;
    end else begin
      infl            <= (infl & ~grant_mask) | drain_mask;
      err_double_free <= dbl_free;
    end
  end
`else
  assign err_double_free = 1'b0;
`endif

  a_reclaim_range: assert property (@(posedge clk) disable iff (!rst_n)
    (reclaim_valid & ~rec_hi) == '0)
    else $fatal(1, "pr_allocator reclaim of architectural PR");

endmodule

// File: tb/tb_pr_allocator.sv
// Scoreboard bench for pr_allocator: a driver issues per-cycle stimulus and queues the
// response predicted by a queue-based free-list model; a monitor pops and compares
// every presented cycle. Directed scenarios first, then randomized traffic.
module tb_pr_allocator;
  import pr_allocator_pkg::*;

  localparam int N   = 64;
  localparam int S   = 2;
  localparam int PRW = 6;
  localparam int D   = N - NUM_ARCH_REGS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [S-1:0]     alloc_req;
  logic [S-1:0]     alloc_gnt;
  logic [PRW-1:0]   alloc_pr [S];
  logic [S-1:0]     rf_alloc_wen;
  logic [PRW-1:0]   rf_alloc_pr [S];
  logic [S-1:0]     reclaim_valid;
  pr_idx_t          reclaim_pr [S];
  logic [N-1:0]     pr_not_idle;
  logic [PRW:0]     free_count;
  logic             free_empty;
  logic             err_double_free;

  pr_allocator #(.NUM_PHY_REGS(N), .NUM_SICS(S)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_req       (alloc_req),
    .alloc_gnt       (alloc_gnt),
    .alloc_pr        (alloc_pr),
    .rf_alloc_wen    (rf_alloc_wen),
    .rf_alloc_pr     (rf_alloc_pr),
    .reclaim_valid   (reclaim_valid),
    .reclaim_pr      (reclaim_pr),
    .pr_not_idle     (pr_not_idle),
    .free_count      (free_count),
    .free_empty      (free_empty),
    .err_double_free (err_double_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] gnt;
    int         pr0;
    int         pr1;
    int         cnt;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   free_q[$];
  int   held[$];
  bit   pend_m [N];
  bit   err_m;
  int   n_chk = 0;
  int   n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    free_q.delete();
    held.delete();
    for (int p = NUM_ARCH_REGS; p < N; p++) free_q.push_back(p);
    for (int p = 0; p < N; p++) pend_m[p] = 1'b0;
    err_m = 1'b0;
  endfunction

  function automatic void take_held(input int v);
    for (int i = 0; i < held.size(); i++) begin
      if (held[i] == v) begin
        held.delete(i);
        return;
      end
    end
  endfunction

  // One cycle: drive inputs at negedge, predict the response, advance the model.
  task automatic step(input logic [1:0] req, input logic [1:0] rv, input int rp0,
                      input int rp1, input logic [N-1:0] nidle);
    exp_t       e;
    int         n;
    int         d;
    int         rp [S];
    logic [1:0] acc;
    bit         isfree;
    @(negedge clk);
    alloc_req     = req;
    reclaim_valid = rv;
    reclaim_pr[0] = PRW'(rp0);
    reclaim_pr[1] = PRW'(rp1);
    pr_not_idle   = nidle;
    rp[0] = rp0;
    rp[1] = rp1;
    e.cnt = free_q.size();
    e.err = err_m;
    e.gnt = 2'b00;
    e.pr0 = 0;
    e.pr1 = 0;
    n = 0;
    if (req[0] && n < e.cnt) begin e.gnt[0] = 1'b1; e.pr0 = free_q[n]; n++; end
    if (req[1] && n < e.cnt) begin e.gnt[1] = 1'b1; e.pr1 = free_q[n]; n++; end
    exp_q.push_back(e);
    err_m = 1'b0;
    acc   = rv;
`ifdef PRA_DOUBLE_FREE_CHECK_EN
    for (int s = 0; s < S; s++) begin
      if (rv[s]) begin
        isfree = 1'b0;
        foreach (free_q[i]) if (free_q[i] == rp[s]) isfree = 1'b1;
        if (isfree || pend_m[rp[s]]) begin
          acc[s] = 1'b0;
          err_m  = 1'b1;
        end
      end
    end
`else
    isfree = 1'b0;
`endif
    d = -1;
    for (int p = NUM_ARCH_REGS; p < N; p++) begin
      if (pend_m[p] && !nidle[p]) begin d = p; break; end
    end
    for (int i = 0; i < n; i++) held.push_back(free_q.pop_front());
    if (d >= 0) begin
      pend_m[d] = 1'b0;
      free_q.push_back(d);
    end
    for (int s = 0; s < S; s++) if (acc[s]) pend_m[rp[s]] = 1'b1;
  endtask

  // Monitor: compares every cycle for which the driver queued a prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("alloc_gnt", alloc_gnt, e.gnt);
        chk("alloc_pr0", alloc_pr[0], e.pr0);
        chk("alloc_pr1", alloc_pr[1], e.pr1);
        chk("rf_alloc_wen", rf_alloc_wen, e.gnt);
        chk("rf_alloc_pr0", rf_alloc_pr[0], e.pr0);
        chk("rf_alloc_pr1", rf_alloc_pr[1], e.pr1);
        chk("free_count", free_count, e.cnt);
        chk("free_empty", free_empty, (e.cnt == 0));
        chk("err_double_free", err_double_free, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   rv;
    int           rp [S];
    logic [N-1:0] ni;
    int           k;
    alloc_req     = '0;
    reclaim_valid = '0;
    reclaim_pr[0] = '0;
    reclaim_pr[1] = '0;
    pr_not_idle   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, then first dual grant.
    step(2'b00, 2'b00, 0, 0, '0);
    #3 chk("reset_free_count", free_count, D);
    step(2'b11, 2'b00, 0, 0, '0);
    #3;
    chk("first_gnt", alloc_gnt, 2'b11);
    chk("first_pr0", alloc_pr[0], 32);
    chk("first_pr1", alloc_pr[1], 33);
    chk("first_rf_wen", rf_alloc_wen, 2'b11);

    // Exhaust the free store; the 17th dual request is refused.
    repeat (15) step(2'b11, 2'b00, 0, 0, '0);
    step(2'b11, 2'b00, 0, 0, '0);
    #3;
    chk("empty_gnt", alloc_gnt, 2'b00);
    chk("empty_pr0", alloc_pr[0], 0);
    chk("empty_count", free_count, 0);
    chk("empty_flag", free_empty, 1'b1);

    // PR40 reclaimed while busy stays pending, then returns once idle.
    take_held(40);
    ni = '0;
    ni[40] = 1'b1;
    step(2'b00, 2'b01, 40, 0, ni);
    repeat (3) step(2'b00, 2'b00, 0, 0, ni);
    #3 chk("busy_count", free_count, 0);
    step(2'b00, 2'b00, 0, 0, '0);
    // Single entry left, both request: only SIC0 wins.
    step(2'b11, 2'b00, 0, 0, '0);
    #3;
    chk("one_left_count", free_count, 1);
    chk("one_left_gnt", alloc_gnt, 2'b01);
    chk("one_left_pr", alloc_pr[0], 40);
    step(2'b00, 2'b00, 0, 0, '0);
    #3 chk("one_left_after", free_count, 0);

    // Randomized traffic: reclaims drawn from PRs currently handed out.
    for (int c = 0; c < 400; c++) begin
      rv = 2'b00;
      rp[0] = 0;
      rp[1] = 0;
      for (int s = 0; s < S; s++) begin
        if (held.size() > 0 && $urandom_range(2) == 0) begin
          k = $urandom_range(held.size() - 1);
          rv[s] = 1'b1;
          rp[s] = held[k];
          held.delete(k);
        end
      end
      ni = {$urandom, $urandom} & {$urandom, $urandom};
      step(2'($urandom), rv, rp[0], rp[1], ni);
    end
    repeat (4) step(2'b00, 2'b00, 0, 0, '0);

    // Mid-cycle reset with count=10 and PR45 pending.
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    repeat (11) step(2'b11, 2'b00, 0, 0, '0);
    take_held(45);
    ni = '0;
    ni[45] = 1'b1;
    step(2'b00, 2'b01, 45, 0, ni);
    @(negedge clk);
    alloc_req     = 2'b11;
    reclaim_valid = 2'b00;
    pr_not_idle   = '0;
    #3 chk("pre_rst_count", free_count, 10);
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", alloc_gnt, 2'b00);
    chk("rst_pr0", alloc_pr[0], 0);
    chk("rst_rf_wen", rf_alloc_wen, 2'b00);
    @(negedge clk);
    alloc_req = 2'b00;
    rst_n = 1'b1;
    model_reset();
    repeat (3) step(2'b00, 2'b00, 0, 0, '0);
    #3;
    chk("post_rst_count", free_count, D);
    chk("post_rst_err", err_double_free, 1'b0);

`ifdef PRA_DOUBLE_FREE_CHECK_EN
    // PR63 is still free: the reclaim is a double free and is dropped.
    step(2'b00, 2'b01, 63, 0, '0);
    step(2'b00, 2'b00, 0, 0, '0);
    #3;
    chk("dbl_err_pulse", err_double_free, 1'b1);
    chk("dbl_count", free_count, D);
    step(2'b00, 2'b00, 0, 0, '0);
    #3 chk("dbl_err_clear", err_double_free, 1'b0);
`endif

    repeat (2) step(2'b00, 2'b00, 0, 0, '0);
    @(negedge clk);
    #3 chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
